// File: rtl/apb_arbiter_master.sv
// Two-port round-robin APB master sharing one slave; one transfer in flight at a time.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT cycles.
module apb_arbiter_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_write,
    input  logic [31:0]       req0_wdata,
    input  logic [3:0]        req0_strb,
    output logic              req0_done,
    output logic [31:0]       req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_write,
    input  logic [31:0]       req1_wdata,
    input  logic [3:0]        req1_strb,
    output logic              req1_done,
    output logic [31:0]       req1_rdata,
    output logic              req1_err,
    output logic              apb_sel,
    output logic              apb_enable,
    output logic              apb_write,
    output logic [ADDR_W-1:0] apb_addr,
    output logic [31:0]       apb_wdata,
    output logic [3:0]        apb_strb,
    input  logic [31:0]       apb_rdata,
    input  logic              apb_ready,
    input  logic              apb_slverr
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_grant;
    logic                r_last_grant;
    logic                r_apb_write;
    logic [ADDR_W-1:0]   r_apb_addr;
    logic [DATA_W-1:0]   r_apb_wdata;
    logic [3:0]          r_apb_strb;
    logic                w_req_any;
    logic                w_pick;
    logic                w_finish;
    logic                w_done;
    logic                w_abort;

    generate
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("TIMEOUT must be at least 1");
        end
    endgenerate

    assign w_req_any = req0_valid | req1_valid;
    // Contention goes to the port that was not served last.
    assign w_pick    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Abort in the stalled ACCESS cycle that brings the stall count up to TIMEOUT.
    assign w_abort = (r_state == S_ACCESS) && !apb_ready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_state_nxt == S_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !apb_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE:   if (w_req_any) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (apb_ready || w_abort) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // A reset landing on the completing cycle abandons the transfer silently.
    assign w_done = w_finish & ~rst;

    always_comb begin
        req0_done  = 1'b0;
        req0_rdata = '0;
        req0_err   = 1'b0;
        req1_done  = 1'b0;
        req1_rdata = '0;
        req1_err   = 1'b0;
        if (w_done) begin
            if (r_grant) begin
                req1_done  = 1'b1;
                req1_err   = w_abort | apb_slverr;
                req1_rdata = w_abort ? '0 : apb_rdata;
            end else begin
                req0_done  = 1'b1;
                req0_err   = w_abort | apb_slverr;
                req0_rdata = w_abort ? '0 : apb_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_apb_write  <= 1'b0;
            r_apb_addr   <= '0;
            r_apb_wdata  <= '0;
            r_apb_strb   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && w_req_any) begin
                r_grant     <= w_pick;
                r_apb_write <= w_pick ? req1_write : req0_write;
                r_apb_addr  <= w_pick ? req1_addr  : req0_addr;
                r_apb_wdata <= w_pick ? req1_wdata : req0_wdata;
                r_apb_strb  <= w_pick ? req1_strb  : req0_strb;
            end
            if (w_finish) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign apb_sel    = (r_state != S_IDLE);
    assign apb_enable = (r_state == S_ACCESS);
    assign apb_write  = r_apb_write;
    assign apb_addr   = r_apb_addr;
    assign apb_wdata  = r_apb_wdata;
    assign apb_strb   = r_apb_strb;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Bench for apb_arbiter_master: byte-memory slave with programmable wait states and a
// reference model of memory contents, round-robin order and completion timing.
module tb_apb_arbiter_master;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req0_write, req0_done, req0_err;
    logic [ADDR_W-1:0] req0_addr;
    logic [31:0] req0_wdata, req0_rdata;
    logic [3:0] req0_strb;
    logic req1_valid, req1_write, req1_done, req1_err;
    logic [ADDR_W-1:0] req1_addr;
    logic [31:0] req1_wdata, req1_rdata;
    logic [3:0] req1_strb;
    logic apb_sel, apb_enable, apb_write, apb_ready, apb_slverr;
    logic [ADDR_W-1:0] apb_addr;
    logic [31:0] apb_wdata, apb_rdata;
    logic [3:0] apb_strb;

    always #5 clk = ~clk;

    apb_arbiter_master #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_write(req0_write),
        .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_write(req1_write),
        .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
        .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_strb(apb_strb),
        .apb_rdata(apb_rdata), .apb_ready(apb_ready), .apb_slverr(apb_slverr)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } xfer_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } done_t;

    // Slave: byte memory, ready after sl_waits stalled ACCESS cycles.
    logic [7:0] sl_mem [256];
    int   sl_waits;
    logic sl_err, sl_never;
    int   acc_cnt;

    assign apb_ready  = ~sl_never & (acc_cnt >= sl_waits);
    assign apb_slverr = sl_err;
    assign apb_rdata  = {sl_mem[apb_addr[7:0] + 8'd3], sl_mem[apb_addr[7:0] + 8'd2],
                         sl_mem[apb_addr[7:0] + 8'd1], sl_mem[apb_addr[7:0]]};

    logic [7:0] ref_mem [256];
    int ref_last;

    xfer_t q0[$];
    xfer_t q1[$];
    done_t done_log[$];
    int cyc;
    int n_checks, n_fails;

    logic s_done0, s_done1, s_wait, s_wr, s_err;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_strb;

    function automatic xfer_t mk(input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        xfer_t x;
        x.wr = wr; x.addr = a; x.wdata = d; x.strb = s;
        return x;
    endfunction

    function automatic logic [31:0] ref_read(input logic [7:0] a);
        return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    task automatic ref_write(input xfer_t x);
        for (int b = 0; b < 4; b++)
            if (x.strb[b]) ref_mem[x.addr[7:0] + 8'(b)] = x.wdata[8*b +: 8];
    endtask

    // One clock: requester and slave bookkeeping after the edge, sampling at negedge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (s_done0 && q0.size() != 0) void'(q0.pop_front());
        if (s_done1 && q1.size() != 0) void'(q1.pop_front());
        if (s_wr && !s_err)
            for (int b = 0; b < 4; b++)
                if (s_strb[b]) sl_mem[s_addr[7:0] + 8'(b)] = s_wdata[8*b +: 8];
        acc_cnt = s_wait ? acc_cnt + 1 : 0;
        if (q0.size() != 0) begin
            req0_valid = 1'b1; req0_addr = q0[0].addr; req0_write = q0[0].wr;
            req0_wdata = q0[0].wdata; req0_strb = q0[0].strb;
        end else begin
            req0_valid = 1'b0;
        end
        if (q1.size() != 0) begin
            req1_valid = 1'b1; req1_addr = q1[0].addr; req1_write = q1[0].wr;
            req1_wdata = q1[0].wdata; req1_strb = q1[0].strb;
        end else begin
            req1_valid = 1'b0;
        end
        @(negedge clk);
        s_done0 = req0_done;
        s_done1 = req1_done;
        s_wait  = apb_sel & apb_enable & ~apb_ready;
        s_wr    = apb_sel & apb_enable & apb_ready & apb_write & ~rst;
        s_err   = apb_slverr;
        s_addr  = apb_addr;
        s_wdata = apb_wdata;
        s_strb  = apb_strb;
        if (req0_done) done_log.push_back('{0, req0_rdata, req0_err, cyc});
        if (req1_done) done_log.push_back('{1, req1_rdata, req1_err, cyc});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        step();
        step();
        rst = 1'b0;
        done_log.delete();
        ref_last = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({apb_sel, apb_enable} !== 2'b00) begin
            n_fails++; $display("FAIL reset_sel_en: got %b expected 00", {apb_sel, apb_enable});
        end
        n_checks++;
        if ({apb_write, apb_addr, apb_wdata, apb_strb} !== '0) begin
            n_fails++; $display("FAIL reset_apb_bus: got addr %h wdata %h strb %b write %b expected all 0",
                                apb_addr, apb_wdata, apb_strb, apb_write);
        end
        n_checks++;
        if ({req0_done, req1_done, req0_err, req1_err, req0_rdata, req1_rdata} !== '0) begin
            n_fails++; $display("FAIL reset_req_outputs: got done %b%b err %b%b rdata %h %h expected all 0",
                                req0_done, req1_done, req0_err, req1_err, req0_rdata, req1_rdata);
        end
        repeat (3) step();
        n_checks++;
        if (apb_sel !== 1'b0 || done_log.size() != 0) begin
            n_fails++; $display("FAIL reset_idle_quiet: got sel %b dones %0d expected 0 0", apb_sel, done_log.size());
        end
    endtask

    task automatic test_single_read();
        done_log.delete();
        sl_waits = 0;
        q0.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
        step();
        n_checks++;
        if (apb_sel !== 1'b0) begin
            n_fails++; $display("FAIL read_idle_sel: got %b expected 0", apb_sel);
        end
        step();
        n_checks++;
        if ({apb_sel, apb_enable} !== 2'b10 || apb_addr !== 32'h10) begin
            n_fails++; $display("FAIL read_setup: got sel/en %b addr %h expected 10 00000010", {apb_sel, apb_enable}, apb_addr);
        end
        step();
        n_checks++;
        if ({apb_sel, apb_enable, req0_done, req1_done} !== 4'b1110) begin
            n_fails++; $display("FAIL read_access_done: got sel/en/done0/done1 %b expected 1110",
                                {apb_sel, apb_enable, req0_done, req1_done});
        end
        n_checks++;
        if (req0_rdata !== 32'h13121110 || req0_err !== 1'b0) begin
            n_fails++; $display("FAIL read_data: got %h err %b expected 13121110 err 0", req0_rdata, req0_err);
        end
        step();
        n_checks++;
        if ({apb_sel, req0_done} !== 2'b00 || req0_rdata !== 32'h0) begin
            n_fails++; $display("FAIL read_after: got sel %b done %b rdata %h expected 0 0 0", apb_sel, req0_done, req0_rdata);
        end
        step();
    endtask

    task automatic test_write_strobe();
        xfer_t x;
        x = mk(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        done_log.delete();
        q1.push_back(x);
        step();
        for (int k = 1; k <= 2; k++) begin
            step();
            n_checks++;
            if (apb_write !== 1'b1 || apb_strb !== 4'b0101 || apb_addr !== 32'h20 || apb_wdata !== 32'hAABBCCDD) begin
                n_fails++; $display("FAIL write_bus_c%0d: got w %b strb %b addr %h wdata %h expected 1 0101 00000020 aabbccdd",
                                    k, apb_write, apb_strb, apb_addr, apb_wdata);
            end
        end
        n_checks++;
        if (req1_done !== 1'b1 || req1_err !== 1'b0 || req0_done !== 1'b0) begin
            n_fails++; $display("FAIL write_done: got done1 %b err1 %b done0 %b expected 1 0 0", req1_done, req1_err, req0_done);
        end
        ref_write(x);
        step();
        step();
        q0.push_back(mk(1'b0, 32'h20, 32'h0, 4'h0));
        repeat (3) step();
        n_checks++;
        if (req0_done !== 1'b1 || req0_rdata !== 32'h23BB21DD) begin
            n_fails++; $display("FAIL write_readback: got done %b rdata %h expected 1 23bb21dd", req0_done, req0_rdata);
        end
        step();
    endtask

    task automatic test_contention();
        int t0;
        logic [31:0] a;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            q0.push_back(mk(1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'h0));
            q1.push_back(mk(1'b0, 32'h80 + 32'(4 * k), 32'h0, 4'h0));
        end
        step();
        t0 = cyc;
        repeat (20) step();
        n_checks++;
        if (done_log.size() != 6) begin
            n_fails++; $display("FAIL contention_count: got %0d expected 6", done_log.size());
        end
        for (int i = 0; i < 6 && i < done_log.size(); i++) begin
            a = ((i % 2) == 0 ? 32'h40 : 32'h80) + 32'(4 * (i / 2));
            n_checks++;
            if (done_log[i].port != (i % 2) || done_log[i].cyc != t0 + 2 + 3 * i ||
                done_log[i].rdata !== ref_read(a[7:0])) begin
                n_fails++; $display("FAIL contention_%0d: got port %0d cyc %0d rdata %h expected port %0d cyc %0d rdata %h",
                                    i, done_log[i].port, done_log[i].cyc, done_log[i].rdata,
                                    i % 2, t0 + 2 + 3 * i, ref_read(a[7:0]));
            end
        end
    endtask

    task automatic test_wait_states();
        int t0;
        done_log.delete();
        sl_waits = 4;
        q0.push_back(mk(1'b0, 32'h30, 32'h0, 4'h0));
        step();
        t0 = cyc;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_checks++;
            if (apb_sel !== 1'b1 || apb_addr !== 32'h30 || apb_write !== 1'b0 || req0_done !== (k == 6)) begin
                n_fails++; $display("FAIL wait_c%0d: got sel %b addr %h write %b done %b expected 1 00000030 0 %b",
                                    k, apb_sel, apb_addr, apb_write, req0_done, (k == 6));
            end
        end
        step();
        step();
        n_checks++;
        if (done_log.size() != 1) begin
            n_fails++; $display("FAIL wait_done_count: got %0d expected 1", done_log.size());
        end else begin
            n_checks++;
            if (done_log[0].cyc != t0 + 6 || done_log[0].rdata !== ref_read(8'h30)) begin
                n_fails++; $display("FAIL wait_done: got cyc %0d rdata %h expected %0d %h",
                                    done_log[0].cyc, done_log[0].rdata, t0 + 6, ref_read(8'h30));
            end
        end
        sl_waits = 0;
    endtask

    task automatic test_error();
        sl_err = 1'b1;
        q0.push_back(mk(1'b0, 32'h34, 32'h0, 4'h0));
        repeat (3) step();
        n_checks++;
        if (req0_done !== 1'b1 || req0_err !== 1'b1) begin
            n_fails++; $display("FAIL slverr: got done %b err %b expected 1 1", req0_done, req0_err);
        end
        sl_err = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        done_log.delete();
        sl_waits = 3;
        q0.push_back(mk(1'b0, 32'h50, 32'h0, 4'h0));
        repeat (3) step();
        n_checks++;
        if (apb_enable !== 1'b1 || req0_done !== 1'b0) begin
            n_fails++; $display("FAIL rstmid_access: got en %b done %b expected 1 0", apb_enable, req0_done);
        end
        rst = 1'b1;
        q0.delete();
        sl_waits = 0;
        #1;
        n_checks++;
        if (req0_done !== 1'b0) begin
            n_fails++; $display("FAIL rstmid_no_done: got %b expected 0", req0_done);
        end
        step();
        n_checks++;
        if ({apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_strb,
             req0_done, req1_done, req0_err, req1_err, req0_rdata, req1_rdata} !== '0) begin
            n_fails++; $display("FAIL rstmid_outputs: got sel %b en %b addr %h done %b%b expected all 0",
                                apb_sel, apb_enable, apb_addr, req0_done, req1_done);
        end
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if (apb_sel !== 1'b0 || done_log.size() != 0) begin
            n_fails++; $display("FAIL rstmid_abandon: got sel %b dones %0d expected 0 0", apb_sel, done_log.size());
        end
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t0;
        apply_reset();
        sl_waits = 0;
        sl_never = 1'b1;
        q0.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
        q1.push_back(mk(1'b0, 32'h14, 32'h0, 4'h0));
        step();
        t0 = cyc;
        repeat (17) step();
        n_checks++;
        if (done_log.size() != 1) begin
            n_fails++; $display("FAIL timeout_count: got %0d expected 1", done_log.size());
        end else begin
            n_checks++;
            if (done_log[0].port != 0 || done_log[0].cyc != t0 + 17 || done_log[0].err !== 1'b1 ||
                done_log[0].rdata !== 32'h0) begin
                n_fails++; $display("FAIL timeout_abort: got port %0d cyc %0d err %b rdata %h expected 0 %0d 1 0",
                                    done_log[0].port, done_log[0].cyc, done_log[0].err, done_log[0].rdata, t0 + 17);
            end
        end
        sl_never = 1'b0;
        repeat (4) step();
        n_checks++;
        if (done_log.size() != 2) begin
            n_fails++; $display("FAIL timeout_next_count: got %0d expected 2", done_log.size());
        end else begin
            n_checks++;
            if (done_log[1].port != 1 || done_log[1].cyc != t0 + 20 || done_log[1].err !== 1'b0 ||
                done_log[1].rdata !== ref_read(8'h14)) begin
                n_fails++; $display("FAIL timeout_next: got port %0d cyc %0d err %b rdata %h expected 1 %0d 0 %h",
                                    done_log[1].port, done_log[1].cyc, done_log[1].err, done_log[1].rdata,
                                    t0 + 20, ref_read(8'h14));
            end
        end
    endtask
`endif

    task automatic test_random();
        int t0, pat, w, nexp, exp_cyc;
        logic e;
        int ep[2];
        xfer_t ex[2];
        xfer_t x0, x1;
        apply_reset();
        for (int r = 0; r < 20; r++) begin
            pat = $urandom_range(1, 3);
            w   = $urandom_range(0, 3);
            e   = ($urandom_range(0, 4) == 0);
            sl_waits = w;
            sl_err   = e;
            x0 = mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom, 4'($urandom_range(0, 15)));
            x1 = mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom, 4'($urandom_range(0, 15)));
            if (pat == 3) begin
                nexp = 2;
                ep[0] = (ref_last == 1) ? 0 : 1;
                ep[1] = 1 - ep[0];
            end else begin
                nexp = 1;
                ep[0] = (pat == 1) ? 0 : 1;
                ep[1] = 0;
            end
            ex[0] = (ep[0] == 0) ? x0 : x1;
            ex[1] = (ep[1] == 0) ? x0 : x1;
            if (pat[0]) q0.push_back(x0);
            if (pat[1]) q1.push_back(x1);
            done_log.delete();
            step();
            t0 = cyc;
            for (int k = 0; k < 60 && (q0.size() != 0 || q1.size() != 0); k++) step();
            step();
            n_checks++;
            if (done_log.size() != nexp) begin
                n_fails++; $display("FAIL rand_count round %0d: got %0d expected %0d", r, done_log.size(), nexp);
            end
            for (int i = 0; i < nexp && i < done_log.size(); i++) begin
                exp_cyc = t0 + 2 + w + i * (3 + w);
                n_checks++;
                if (done_log[i].port != ep[i] || done_log[i].cyc != exp_cyc || done_log[i].err !== e) begin
                    n_fails++; $display("FAIL rand_xfer round %0d #%0d: got port %0d cyc %0d err %b expected %0d %0d %b",
                                        r, i, done_log[i].port, done_log[i].cyc, done_log[i].err, ep[i], exp_cyc, e);
                end
                if (!ex[i].wr) begin
                    n_checks++;
                    if (done_log[i].rdata !== ref_read(ex[i].addr[7:0])) begin
                        n_fails++; $display("FAIL rand_rdata round %0d #%0d: got %h expected %h",
                                            r, i, done_log[i].rdata, ref_read(ex[i].addr[7:0]));
                    end
                end else if (!e) begin
                    ref_write(ex[i]);
                end
            end
            ref_last = ep[nexp - 1];
            sl_err = 1'b0;
        end
        sl_waits = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_write = 1'b0; req0_wdata = '0; req0_strb = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_write = 1'b0; req1_wdata = '0; req1_strb = '0;
        sl_waits = 0; sl_err = 1'b0; sl_never = 1'b0; acc_cnt = 0;
        s_done0 = 1'b0; s_done1 = 1'b0; s_wait = 1'b0; s_wr = 1'b0; s_err = 1'b0;
        s_addr = '0; s_wdata = '0; s_strb = '0;
        cyc = 0; n_checks = 0; n_fails = 0; ref_last = 1;
        for (int i = 0; i < 256; i++) begin
            sl_mem[i]  = 8'(i);
            ref_mem[i] = 8'(i);
        end
        test_reset();
        test_single_read();
        test_write_strobe();
        test_contention();
        test_wait_states();
        test_error();
        test_reset_mid();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
